// File: rtl/alu_pkg.sv
// alu_pkg: types and constants shared by the ALU result buffer slice.
//   alu_sel_t      : 4-bit opcode that produced a result (ALU opcode map)
//   alu_res_t      : packed storage entry {sel, carry, data}
//   ALU_RES_DATA_W : widest result the entry can hold; narrower results are
//                    zero-extended, so the unused upper bits stay constant
//   ALU_STAT_W     : width of the statistics counters
package alu_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'h0,
        ALU_SUB  = 4'h1,
        ALU_MUL  = 4'h2,
        ALU_DIV  = 4'h3,
        ALU_SHL  = 4'h4,
        ALU_SHR  = 4'h5,
        ALU_ROL  = 4'h6,
        ALU_ROR  = 4'h7,
        ALU_AND  = 4'h8,
        ALU_OR   = 4'h9,
        ALU_XOR  = 4'hA,
        ALU_NOR  = 4'hB,
        ALU_NAND = 4'hC,
        ALU_XNOR = 4'hD,
        ALU_GT   = 4'hE,
        ALU_EQ   = 4'hF
    } alu_sel_t;

    localparam int ALU_RES_DATA_W = 32;
    localparam int ALU_STAT_W     = 16;

    typedef struct packed {
        alu_sel_t                  sel;
        logic                      carry;
        logic [ALU_RES_DATA_W-1:0] data;
    } alu_res_t;

endpackage

// File: rtl/alu_res_stats.sv
// alu_res_stats: saturating pair of beat counters for the result buffer.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear, wins over a same-cycle increment
//   inc        : one beat accepted this cycle
//   inc_carry  : accepted beat had carry set
//   total      : accepted beats, saturates at all-ones
//   carry_cnt  : accepted beats with carry, saturates at all-ones
module alu_res_stats
    import alu_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  inc,
    input  logic                  inc_carry,
    output logic [ALU_STAT_W-1:0] total,
    output logic [ALU_STAT_W-1:0] carry_cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            total     <= '0;
            carry_cnt <= '0;
        end else if (clr) begin
            total     <= '0;
            carry_cnt <= '0;
        end else begin
            if (inc && (total != '1))
                total <= total + ALU_STAT_W'(1);
            if (inc_carry && (carry_cnt != '1))
                carry_cnt <= carry_cnt + ALU_STAT_W'(1);
        end
    end

endmodule

// File: rtl/alu_result_fifo.sv
// alu_result_fifo: registered capture buffer behind the combinational ALU.
// Each accepted beat stores {ALU_Sel, CarryOut, ALU_Out}; entries are replayed
// in order over a valid/ready handshake.
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid / in_ready  : producer handshake (in_ready = !full, registered only)
//   in_data/carry/sel    : ALU result, carry and opcode tag
//   out_valid / out_ready: consumer handshake (out_valid = !empty)
//   out_data/carry/sel   : head entry, forced to zero while empty
//   out_zero             : head data is zero, qualified by out_valid
//   count                : occupancy, 0..DEPTH
// Optional feature macro ALU_RES_STATS_EN adds stat_clr, stat_total and
// stat_carry (saturating beat counters).
module alu_result_fifo
    import alu_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        in_data,
    input  logic                     in_carry,
    input  logic [3:0]               in_sel,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_carry,
    output logic [3:0]               out_sel,
    output logic                     out_zero,
    output logic [$clog2(DEPTH):0]   count
`ifdef ALU_RES_STATS_EN
    ,
    input  logic                     stat_clr,
    output logic [ALU_STAT_W-1:0]    stat_total,
    output logic [ALU_STAT_W-1:0]    stat_carry
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("alu_result_fifo: DEPTH must be a power of two and at least 2");
    end
    if (DATA_W > ALU_RES_DATA_W) begin : g_bad_width
        $error("alu_result_fifo: DATA_W exceeds the entry data width");
    end

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt;
    alu_res_t         mem [DEPTH];
    alu_res_t         head;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;

    assign full  = (cnt == CNT_W'(DEPTH));
    assign empty = (cnt == '0);

    // in_ready comes from registered occupancy only, so a full buffer turns
    // away a push even when the consumer pops in the same cycle.
    assign push = in_valid && !full;
    assign pop  = !empty && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= '{sel:   alu_sel_t'(in_sel),
                                 carry: in_carry,
                                 data:  ALU_RES_DATA_W'(in_data)};
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Outputs come straight from storage and occupancy, so they drop the
    // moment rst_n asserts and never show an entry in its push cycle.
    assign head      = mem[rd_ptr];
    assign in_ready  = !full;
    assign out_valid = !empty;
    assign count     = cnt;
    assign out_data  = out_valid ? head.data[DATA_W-1:0] : '0;
    assign out_carry = out_valid && head.carry;
    assign out_sel   = out_valid ? head.sel : 4'h0;
    // Upper entry bits are always zero, so comparing the full field is exact.
    assign out_zero  = out_valid && (head.data == '0);

`ifdef ALU_RES_STATS_EN
    alu_res_stats u_stats (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (stat_clr),
        .inc       (push),
        .inc_carry (push && in_carry),
        .total     (stat_total),
        .carry_cnt (stat_carry)
    );
`endif

endmodule

// File: tb/tb_alu_result_fifo.sv
// Scoreboard bench for alu_result_fifo (DATA_W=8, DEPTH=4). Stimulus enqueues
// the beats it expects to be accepted; the monitor compares every handshaked
// output beat against the queue head. Stats checks apply when
// ALU_RES_STATS_EN is defined.
module tb_alu_result_fifo;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = 8'h00;
    logic       in_carry = 1'b0;
    logic [3:0] in_sel = 4'h0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
    logic       out_carry;
    logic [3:0] out_sel;
    logic       out_zero;
    logic [2:0] count;
`ifdef ALU_RES_STATS_EN
    logic        stat_clr = 1'b0;
    logic [15:0] stat_total;
    logic [15:0] stat_carry;
`endif

    alu_result_fifo #(.DATA_W(8), .DEPTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_carry  (in_carry),
        .in_sel    (in_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_carry (out_carry),
        .out_sel   (out_sel),
        .out_zero  (out_zero),
        .count     (count)
`ifdef ALU_RES_STATS_EN
        ,
        .stat_clr  (stat_clr),
        .stat_total(stat_total),
        .stat_carry(stat_carry)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       carry;
        logic [3:0] sel;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_chk  = 0;
    int   n_pass = 0;

    logic [7:0] fill_d [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act === req)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", nm, act, req, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] d, input logic c, input logic [3:0] s, input bit accept);
        in_valid = 1'b1;
        in_data  = d;
        in_carry = c;
        in_sel   = s;
        if (accept)
            exp_q.push_back('{d, c, s});
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_data  = 8'h00;
        in_carry = 1'b0;
        in_sel   = 4'h0;
    endtask

    task automatic wait_empty(input string nm);
        out_ready = 1'b1;
        for (int i = 0; i < 40 && count != 3'd0; i++)
            step();
        out_ready = 1'b0;
        check(nm, 32'(count), 0);
    endtask

    // Monitor: compare each handshaked beat, and zeroed outputs while empty.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL mon_extra: got beat 0x%0h, required none", out_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("mon_beat", 32'({out_sel, out_carry, out_data, out_zero}),
                          32'({mon_e.sel, mon_e.carry, mon_e.data, (mon_e.data == 8'h00)}));
                end
            end else if (!out_valid) begin
                check("idle_zero", 32'({out_sel, out_carry, out_data, out_zero}), 0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1);
    end

    initial begin
        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check("rst_count", 32'(count), 0);
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_data", 32'(out_data), 0);
`ifdef ALU_RES_STATS_EN
        check("rst_stats", {stat_total, stat_carry}, 0);
`endif
        rst_n = 1'b1;
        step();

        // Single push: visible one cycle later, no fall-through
        drive(8'h3C, 1'b0, 4'b1010, 1'b1);
        @(negedge clk);
        check("no_fallthru", 32'(out_valid), 0);
        step();
        idle();
        @(negedge clk);
        check("single_valid", 32'(out_valid), 1);
        check("single_data", 32'(out_data), 32'h3C);
        check("single_sel", 32'(out_sel), 32'hA);
        check("single_zero", 32'(out_zero), 0);
        check("single_count", 32'(count), 1);
        step();
        wait_empty("single_drain");

        // Fill to full with the consumer stalled
        for (int i = 0; i < 4; i++) begin
            drive(fill_d[i], i[0], 4'(i + 2), 1'b1);
            step();
            check("fill_count", 32'(count), 32'(i + 1));
        end
        idle();
        check("full_in_ready", 32'(in_ready), 0);
        drive(8'hFF, 1'b1, 4'hF, 1'b0);
        step();
        idle();
        check("full_drop_count", 32'(count), 4);
        check("full_head", 32'(out_data), 32'h11);
        out_ready = 1'b1;
        for (int k = 3; k >= 0; k--) begin
            step();
            check("drain_count", 32'(count), 32'(k));
        end
        out_ready = 1'b0;

        // Full with simultaneous push and pop: pop taken, push refused
        for (int i = 0; i < 4; i++) begin
            drive(fill_d[i] ^ 8'hF0, ~i[0], 4'(i + 8), 1'b1);
            step();
        end
        drive(8'h55, 1'b0, 4'h0, 1'b0);
        out_ready = 1'b1;
        step();
        idle();
        out_ready = 1'b0;
        check("simul_count", 32'(count), 3);
        check("simul_in_ready", 32'(in_ready), 1);
        wait_empty("simul_drain");

        // Streaming 10 beats at one per cycle with pointer wrap
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive(8'(i * 37 + 5), i[1], 4'(i), 1'b1);
            step();
            check("stream_count", 32'(count), 1);
        end
        idle();
        step();
        check("stream_end_count", 32'(count), 0);
        out_ready = 1'b0;

        // Asynchronous reset with entries queued
        for (int i = 0; i < 3; i++) begin
            drive(8'(i + 100), 1'b1, 4'h5, 1'b1);
            step();
        end
        idle();
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", 32'(out_valid), 0);
        check("arst_count", 32'(count), 0);
        exp_q.delete();
        step();
        step();
        rst_n = 1'b1;
        step();
        drive(8'h00, 1'b1, 4'h3, 1'b1);
        step();
        idle();
        @(negedge clk);
        check("post_rst_zero", 32'(out_zero), 1);
        check("post_rst_carry", 32'(out_carry), 1);
        step();
        wait_empty("post_rst_drain");

`ifdef ALU_RES_STATS_EN
        stat_clr = 1'b1;
        step();
        stat_clr = 1'b0;
        check("stat_clr_alone", {stat_total, stat_carry}, 0);
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(8'(i + 1), (i == 0) || (i == 2), 4'h0, 1'b1);
            step();
        end
        idle();
        check("stat_total", 32'(stat_total), 5);
        check("stat_carry", 32'(stat_carry), 2);
        drive(8'h77, 1'b1, 4'h1, 1'b1);
        stat_clr = 1'b1;
        step();
        idle();
        stat_clr = 1'b0;
        check("stat_clr_push", {stat_total, stat_carry}, 0);
        out_ready = 1'b0;
        step();
        wait_empty("stat_drain");
`endif

        wait_empty("final_drain");
        check("queue_empty", 32'(exp_q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
